// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace buffer read path.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_SYNC,
    HDR_CNT,
    RD,
    LATCH,
    SEND,
    TRAIL
  } unload_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Ceiling log2, so log2(depth+1) sizes a counter that can hold 0..depth.
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/trace_buffer_unloader_if.sv
// Byte-wide valid/ready stream carrying framed trace data off chip.
interface trace_buffer_unloader_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/trace_word_serializer.sv
// Holds one trace word and presents it a byte at a time, LSB first.
module trace_word_serializer #(
  parameter int Fpay = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [Fpay-1:0] word_i,
  input  logic            advance_i,
  output logic [7:0]      byte_o,
  output logic            last_o
);

  localparam int NBytes = Fpay / 8;
  localparam int IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [Fpay-1:0] shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
    end else if (advance_i) begin
      shift_d = shift_q >> 8;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shift_q[7:0];
  assign last_o = (idx_q == IdxW'(NBytes - 1));

endmodule

// File: rtl/trace_buffer_unloader.sv
// Drains up to MAX_BURST trace words per request and frames them as
// sync, count, LSB-first payload and an XOR checksum of the payload.
module trace_buffer_unloader
  import trace_pkg::*;
#(
  parameter int         Fpay      = 32,
  parameter int         TB_Depth  = 512,
  parameter int         MAX_BURST = 255,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  localparam int        CNTw      = log2(TB_Depth + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNTw-1:0]          fifo_count,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic [Fpay-1:0]          fifo_dout,
  trace_buffer_unloader_if.master  tx,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun_err
);

  unload_state_e   state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [7:0]      checksum_q, checksum_d;
  logic            underrun_q, underrun_d;
  logic [7:0]      burstLen;
  logic            serLoad, serAdvance, serLast;
  logic [Fpay-1:0] serWord;
  logic [7:0]      serByte;

  // N is fixed at start; words pushed during the frame wait for the next one.
  assign burstLen = (int'(fifo_count) > MAX_BURST) ? 8'(MAX_BURST) : 8'(fifo_count);

  trace_word_serializer #(.Fpay(Fpay)) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (serLoad),
    .word_i    (serWord),
    .advance_i (serAdvance),
    .byte_o    (serByte),
    .last_o    (serLast)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    underrun_d  = underrun_q;
    fifo_rd     = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    serLoad     = 1'b0;
    serWord     = '0;
    serAdvance  = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = burstLen;
          checksum_d  = 8'h00;
          underrun_d  = 1'b0;
          state_d     = HDR_SYNC;
        end
      end
      HDR_SYNC: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = SYNC_BYTE;
        if (tx.tx_ready) state_d = HDR_CNT;
      end
      HDR_CNT: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = remaining_q;
        if (tx.tx_ready) state_d = (remaining_q != 8'd0) ? RD : TRAIL;
      end
      RD: begin
        // An empty FIFO mid-frame still yields a word (zeros) to keep the count honest.
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = LATCH;
        end else begin
          serLoad    = 1'b1;
          underrun_d = 1'b1;
          state_d    = SEND;
        end
      end
      LATCH: begin
        serLoad = 1'b1;
        serWord = fifo_dout;
        state_d = SEND;
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = serByte;
        if (tx.tx_ready) begin
          checksum_d = checksum_q ^ serByte;
          serAdvance = 1'b1;
          if (serLast) begin
            remaining_d = remaining_q - 8'd1;
            state_d     = (remaining_q == 8'd1) ? TRAIL : RD;
          end
        end
      end
      TRAIL: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = checksum_q;
        if (tx.tx_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      checksum_q  <= 8'h00;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_trace_buffer_unloader.sv
// Randomised frame bench for trace_buffer_unloader with a FIFO model and
// a byte-stream reference built from the framing rules.
module tb_trace_buffer_unloader;
  import trace_pkg::*;

  localparam int Fpay      = 32;
  localparam int TB_Depth  = 512;
  localparam int MAX_BURST = 255;
  localparam int CNTw      = log2(TB_Depth + 1);
  localparam int NBytes    = Fpay / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [CNTw-1:0] fifo_count = '0;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd;
  logic [Fpay-1:0] fifo_dout = '0;
  logic            busy, done, underrun_err;

  trace_buffer_unloader_if txIf();

  trace_buffer_unloader #(
    .Fpay(Fpay), .TB_Depth(TB_Depth), .MAX_BURST(MAX_BURST), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_dout    (fifo_dout),
    .tx           (txIf.master),
    .busy         (busy),
    .done         (done),
    .underrun_err (underrun_err)
  );

  always #5 clk = ~clk;

  int              vectors = 0;
  int              miscompares = 0;
  logic [Fpay-1:0] fifoQ[$];
  bit              forceEmpty = 1'b0;
  bit              underrunMode = 1'b0;
  int              readyMode = 0;
  logic [7:0]      expQ[$];
  bit              expLast[$];
  int              expIdx = 0;
  logic [7:0]      rxLog[$];
  int              doneCount = 0;
  int              rdPulses = 0;
  logic [7:0]      golden[11] = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                                  8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
  logic [7:0]      goldenEmpty[3] = '{8'hA5, 8'h00, 8'h00};

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic updateFlags();
    fifo_count = (fifoQ.size() > TB_Depth) ? CNTw'(TB_Depth) : CNTw'(fifoQ.size());
    fifo_empty = forceEmpty || (fifoQ.size() == 0);
  endtask

  task automatic loadRandom(input int n);
    fifoQ.delete();
    forceEmpty = 1'b0;
    for (int i = 0; i < n; i++) fifoQ.push_back($urandom);
    updateFlags();
  endtask

  task automatic loadPair();
    fifoQ.delete();
    forceEmpty = 1'b0;
    fifoQ.push_back(32'h11223344);
    fifoQ.push_back(32'hAABBCCDD);
    updateFlags();
  endtask

  // Expected frame: only the first goodWords reads return FIFO data, later words are zero.
  task automatic queueFrame(input int goodWords);
    int n;
    logic [7:0] chk;
    logic [Fpay-1:0] w;
    n = (fifoQ.size() > MAX_BURST) ? MAX_BURST : fifoQ.size();
    chk = 8'h00;
    expQ.push_back(8'hA5);      expLast.push_back(1'b0);
    expQ.push_back(8'(n));      expLast.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      w = (i < goodWords) ? fifoQ[i] : '0;
      for (int b = 0; b < NBytes; b++) begin
        expQ.push_back(w[8*b +: 8]);
        expLast.push_back(1'b0);
        chk = chk ^ w[8*b +: 8];
      end
    end
    expQ.push_back(chk);        expLast.push_back(1'b1);
  endtask

  task automatic applyStimulus(input int goodWords);
    @(negedge clk);
    start = 1'b1;
    queueFrame(goodWords);
    @(negedge clk);
    start = 1'b0;
    checkOutput("first_valid_latency", int'(txIf.tx_valid), 1);
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("underrun_cleared_by_start", int'(underrun_err), 0);
  endtask

  task automatic waitFrameDone(input int budget);
    int base;
    int cycles;
    base = doneCount;
    cycles = 0;
    while (doneCount == base && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    checkOutput("frame_done_in_budget", int'(doneCount != base), 1);
    @(negedge clk);
    #1;
    checkOutput("idle_after_done", int'(busy), 0);
    checkOutput("all_expected_bytes_seen", expIdx, expQ.size());
  endtask

  // FIFO model: data appears on the cycle after the read strobe.
  initial begin
    bit doRead;
    forever begin
      @(negedge clk);
      doRead = fifo_rd;
      @(posedge clk);
      #1;
      if (doRead && fifoQ.size() > 0) begin
        fifo_dout = fifoQ.pop_front();
        if (underrunMode) forceEmpty = 1'b1;
        updateFlags();
      end
    end
  end

  initial begin
    int phase;
    phase = 0;
    txIf.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       txIf.tx_ready = 1'b1;
        1: begin
          txIf.tx_ready = (phase % 4 == 0) || (phase % 4 == 3);
          phase++;
        end
        default: txIf.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: everything visible at the negedge is what the next posedge acts on.
  initial begin
    bit         stalled;
    logic [7:0] heldData;
    bit         expDoneNow;
    stalled = 1'b0;
    heldData = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        expIdx = expQ.size();
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        checkOutput("valid_held_while_stalled", int'(txIf.tx_valid), 1);
        checkOutput("data_held_while_stalled", int'(txIf.tx_data), int'(heldData));
      end
      if (fifo_rd) begin
        rdPulses++;
        checkOutput("no_read_when_empty", int'(fifo_empty), 0);
      end
      expDoneNow = 1'b0;
      if (txIf.tx_valid && txIf.tx_ready) begin
        if (expIdx >= expQ.size()) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", txIf.tx_data);
        end else begin
          checkOutput("tx_byte", int'(txIf.tx_data), int'(expQ[expIdx]));
          expDoneNow = expLast[expIdx];
          expIdx++;
        end
        rxLog.push_back(txIf.tx_data);
      end
      checkOutput("done_pulse", int'(done), int'(expDoneNow));
      if (done) doneCount++;
      stalled = txIf.tx_valid && !txIf.tx_ready;
      heldData = txIf.tx_data;
    end
  end

  initial begin
    int logBase, rdBase, doneBase, waited;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_valid", int'(txIf.tx_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_fifo_rd", int'(fifo_rd), 0);
    checkOutput("reset_underrun", int'(underrun_err), 0);
    reset = 1'b0;

    // Two known words, free-flowing sink and then a 1-0-0-1 ready pattern.
    for (int mode = 0; mode < 2; mode++) begin
      readyMode = mode;
      loadPair();
      logBase = rxLog.size();
      rdBase = rdPulses;
      doneBase = doneCount;
      applyStimulus(1000);
      waitFrameDone(200);
      checkOutput("pair_frame_len", rxLog.size() - logBase, 11);
      for (int i = 0; i < 11; i++)
        if (logBase + i < rxLog.size())
          checkOutput($sformatf("pair_byte%0d", i), int'(rxLog[logBase + i]), int'(golden[i]));
      checkOutput("pair_rd_pulses", rdPulses - rdBase, 2);
      checkOutput("pair_done_pulses", doneCount - doneBase, 1);
    end

    readyMode = 0;
    loadRandom(0);
    logBase = rxLog.size();
    rdBase = rdPulses;
    applyStimulus(1000);
    waitFrameDone(50);
    checkOutput("empty_frame_len", rxLog.size() - logBase, 3);
    for (int i = 0; i < 3; i++)
      if (logBase + i < rxLog.size())
        checkOutput($sformatf("empty_byte%0d", i), int'(rxLog[logBase + i]), int'(goldenEmpty[i]));
    checkOutput("empty_rd_pulses", rdPulses - rdBase, 0);

    loadRandom(300);
    logBase = rxLog.size();
    rdBase = rdPulses;
    applyStimulus(1000);
    waitFrameDone(4000);
    if (logBase + 1 < rxLog.size())
      checkOutput("cap_count_byte", int'(rxLog[logBase + 1]), 8'hFF);
    checkOutput("cap_rd_pulses", rdPulses - rdBase, 255);
    checkOutput("cap_fifo_left", int'(fifo_count), 45);

    // FIFO reports three words but goes empty after the first read.
    loadRandom(3);
    underrunMode = 1'b1;
    logBase = rxLog.size();
    rdBase = rdPulses;
    applyStimulus(1);
    waitFrameDone(200);
    underrunMode = 1'b0;
    checkOutput("underrun_flag_set", int'(underrun_err), 1);
    checkOutput("underrun_rd_pulses", rdPulses - rdBase, 1);
    if (logBase + 13 < rxLog.size())
      checkOutput("underrun_word2_zero", int'({rxLog[logBase + 9], rxLog[logBase + 8],
                                               rxLog[logBase + 7], rxLog[logBase + 6]}), 0);
    repeat (4) @(negedge clk);
    checkOutput("underrun_flag_sticky", int'(underrun_err), 1);

    readyMode = 2;
    for (int f = 0; f < 6; f++) begin
      loadRandom(int'($urandom_range(0, 6)));
      applyStimulus(1000);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      waitFrameDone(600);
    end

    readyMode = 0;
    loadPair();
    logBase = rxLog.size();
    applyStimulus(1000);
    waited = 0;
    while (rxLog.size() < logBase + 5 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("reached_fifth_byte", int'(rxLog.size() >= logBase + 5), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_tx_valid", int'(txIf.tx_valid), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_fifo_rd", int'(fifo_rd), 0);
    reset = 1'b0;
    loadPair();
    logBase = rxLog.size();
    applyStimulus(1000);
    waitFrameDone(200);
    checkOutput("post_reset_frame_len", rxLog.size() - logBase, 11);
    for (int i = 0; i < 11; i++)
      if (logBase + i < rxLog.size())
        checkOutput($sformatf("post_reset_byte%0d", i), int'(rxLog[logBase + i]), int'(golden[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
